mem_stage_sram: RTL and testbench
=================================

Name: mem_stage_sram

Overview:
- MEM stage of the 5-stage pipeline. Sits between the EXE/MEM register and the MEM/WB register, and feeds memReadVal into MEM/WB.
- Services load/store requests against an external 16-bit asynchronous SRAM. Each 32-bit word takes two half-word accesses.
- Holds the whole pipeline with `freeze` until the access completes.
- Non-memory instructions pass through with zero stall.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 2: cycles each half-word strobe is held (≥1).
- SRAM_ADDR_LEN, 18: SRAM address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- MEM_R_EN_IN  in  1  load request from EXE/MEM
- MEM_W_EN_IN  in  1  store request from EXE/MEM
- ALUResIn  in  `WORD_LEN  effective byte address
- stValIn  in  `WORD_LEN  store data
- memReadVal  out  `WORD_LEN  loaded word, to MEM/WB memReadValIn
- freeze  out  1  high = hold PC and all pipeline registers this cycle
- SRAM_ADDR  out  SRAM_ADDR_LEN  half-word address
- SRAM_DQ_OUT  out  16  write data
- SRAM_DQ_OE  out  1  drive enable for the top-level tristate
- SRAM_DQ_IN  in  16  read data
- SRAM_WE_N  out  1  write strobe, active low
- SRAM_OE_N  out  1  output enable, active low

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset (rst) is synchronous and active-high.
  - Reset values: state IDLE, counter 0, memReadVal 0, SRAM_ADDR 0, SRAM_DQ_OUT 0, SRAM_DQ_OE 0, SRAM_WE_N 1, SRAM_OE_N 1.
- Address mapping:
  - off = ALUResIn − BASE_ADDR (32-bit wrap); word = off[SRAM_ADDR_LEN:2].
  - Low half is at {word,0}, high half at {word,1}. Upper bits are dropped silently.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. A counter cnt of width clog2(WAIT_CYCLES)+1 runs in the RD_*/WR_* states.
- IDLE:
  - MEM_W_EN_IN → WR_LO. Store wins if both enables are high.
  - Else MEM_R_EN_IN → RD_LO.
  - Else stay in IDLE.
  - Address and store data are latched on the transition edge.
- RD_LO / RD_HI:
  - SRAM_OE_N=0, SRAM_DQ_OE=0, SRAM_ADDR = low/high address.
  - On the last cycle (cnt==WAIT_CYCLES−1), SRAM_DQ_IN is captured into the low/high half of an internal buffer.
  - Then RD_LO→RD_HI and RD_HI→DONE. cnt is cleared on each transition.
- WR_LO / WR_HI:
  - SRAM_DQ_OE=1, SRAM_DQ_OUT = data[15:0] / data[31:16].
  - SRAM_WE_N=0 for the first WAIT_CYCLES−1 cycles, and 1 on the last cycle (data hold). When WAIT_CYCLES==1, WE_N=0 for the single cycle.
  - Then WR_LO→WR_HI and WR_HI→DONE.
- DONE:
  - For loads, memReadVal = buffer, registered on entry to DONE.
  - freeze=0, so the pipeline advances at this edge. Unconditional →IDLE. Request inputs are ignored in DONE.
- SRAM control outputs are registered, set on the edge entering the state.
- freeze is combinational:
  - High when (state==IDLE && (MEM_R_EN_IN||MEM_W_EN_IN)), or when state ∈ {RD_*, WR_*}. Low otherwise.
  - Exception: a cache hit in IDLE does not raise freeze (see Optional Feature).
- Latency: a load/store freezes for exactly 2·WAIT_CYCLES+1 cycles. With no request, freeze=0 and memReadVal holds its last value.
- Reset mid-access:
  - Abort and return to IDLE.
  - SRAM_WE_N and SRAM_OE_N go to 1 and SRAM_DQ_OE to 0 on the same edge.
  - memReadVal goes to 0. No partial result is kept.
- Back-to-back memory instructions: DONE is always followed by IDLE. The new request re-asserts freeze combinationally in that IDLE cycle.

Optional Feature:
- Macro MEM_STAGE_READ_CACHE_EN: a one-entry cache holding {valid, word address, data}.
- With the macro defined:
  - A load in IDLE whose word address matches a valid entry is a hit: freeze=0, memReadVal is driven from the cache in the same cycle, and state stays IDLE.
  - A miss follows the normal path, and the entry is filled at DONE.
  - A store to the matching address updates the cache data at DONE. A store to another address leaves the cache unchanged.
  - Reset clears valid.
- Without the macro: no cache logic, and every load takes the full latency.

Decomposition:
- Shared package/defines.v holds `WORD_LEN, the state encoding localparams (MS_IDLE…MS_DONE) and the SRAM default widths.
- Natural sub-module: sram_half_access. It holds the cnt counter and strobe generation for one half-word and is instantiated once, driven by the top FSM.

Test Plan:
- Store 0xDEADBEEF to 1024, WAIT_CYCLES=2 → freeze high 5 cycles; SRAM_ADDR 0 then 1; DQ_OUT 0xBEEF then 0xDEAD; WE_N low 1 cycle per half.
- Load from 1024 after the above, SRAM model returns the data → memReadVal=0xDEADBEEF in DONE; freeze high 5 cycles.
- Load and store requests both high, address 1028 → write path taken, SRAM_ADDR 2/3, OE_N stays 1.
- rst asserted in the 2nd cycle of WR_LO → next cycle state IDLE, WE_N=1, DQ_OE=0, freeze=0 with no request present.
- Two consecutive loads (1032, 1036) → two 5-cycle freezes separated by the DONE cycle; correct data for each.
- With MEM_STAGE_READ_CACHE_EN: load 1024 twice → second load freeze=0 and memReadVal valid immediately; store 0x12345678 to 1024 then load → 0x12345678 returned with no freeze.

Source files
------------

// File: rtl/mem_stage_sram_pkg.sv
// Shared types for the MEM stage SRAM controller: word width, SRAM widths, FSM encoding.
// Pure declarations; no logic and no latency of its own.
package mem_stage_sram_pkg;

  localparam int WORD_LEN          = 32;
  localparam int SRAM_DQ_LEN       = 16;
  localparam int SRAM_ADDR_LEN_DEF = 18;

  typedef enum logic [2:0] {
    MS_IDLE  = 3'd0,
    MS_RD_LO = 3'd1,
    MS_RD_HI = 3'd2,
    MS_WR_LO = 3'd3,
    MS_WR_HI = 3'd4,
    MS_DONE  = 3'd5
  } ms_state_t;

  function automatic logic is_read(ms_state_t s);
    return (s == MS_RD_LO) || (s == MS_RD_HI);
  endfunction

  function automatic logic is_write(ms_state_t s);
    return (s == MS_WR_LO) || (s == MS_WR_HI);
  endfunction

  function automatic logic is_access(ms_state_t s);
    return is_read(s) || is_write(s);
  endfunction

  function automatic logic is_hi(ms_state_t s);
    return (s == MS_RD_HI) || (s == MS_WR_HI);
  endfunction

endpackage

// File: rtl/mem_stage_sram_if.sv
// Pipeline-side request/result bus plus the 16-bit SRAM pins of the MEM stage.
// slave = the MEM stage itself, master = whatever drives requests and models the SRAM.
interface mem_stage_sram_if
  import mem_stage_sram_pkg::*;
#(
  parameter int SRAM_ADDR_LEN = SRAM_ADDR_LEN_DEF
) ();

  logic                     MEM_R_EN_IN;
  logic                     MEM_W_EN_IN;
  logic [WORD_LEN-1:0]      ALUResIn;
  logic [WORD_LEN-1:0]      stValIn;
  logic [WORD_LEN-1:0]      memReadVal;
  logic                     freeze;
  logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR;
  logic [SRAM_DQ_LEN-1:0]   SRAM_DQ_OUT;
  logic                     SRAM_DQ_OE;
  logic [SRAM_DQ_LEN-1:0]   SRAM_DQ_IN;
  logic                     SRAM_WE_N;
  logic                     SRAM_OE_N;

  modport slave (
    input  MEM_R_EN_IN, MEM_W_EN_IN, ALUResIn, stValIn, SRAM_DQ_IN,
    output memReadVal, freeze, SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_N, SRAM_OE_N
  );

  modport master (
    output MEM_R_EN_IN, MEM_W_EN_IN, ALUResIn, stValIn, SRAM_DQ_IN,
    input  memReadVal, freeze, SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_N, SRAM_OE_N
  );

endinterface

// File: rtl/mem_stage_sram_half_access.sv
// Per-half-word wait counter and registered SRAM strobes, driven by the MEM stage FSM.
// Strobes take effect on the edge entering a state; 'last' flags the final wait cycle of a half.
module mem_stage_sram_half_access
  import mem_stage_sram_pkg::*;
#(
  parameter int WAIT_CYCLES   = 2,
  parameter int SRAM_ADDR_LEN = SRAM_ADDR_LEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  ms_state_t                state,
  input  ms_state_t                state_n,
  input  logic [SRAM_ADDR_LEN-1:0] addr_n,
  input  logic [SRAM_DQ_LEN-1:0]   wdat_n,
  output logic                     last,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DQ_LEN-1:0]   sram_dq_out,
  output logic                     sram_dq_oe,
  output logic                     sram_we_n,
  output logic                     sram_oe_n
);

  localparam int            CW       = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          we_n_n;

  assign last = (cnt == CNT_LAST);

  // Counter restarts whenever a new half begins or the FSM leaves the access states.
  always_comb begin
    cnt_n = '0;
    if (is_access(state_n) && (state_n == state))
      cnt_n = cnt + CW'(1);
  end

  // Write strobe releases on the last wait cycle to give the SRAM data hold time,
  // unless there is only one cycle to work with.
  assign we_n_n = (WAIT_CYCLES > 1) ? (cnt_n == CNT_LAST) : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      cnt        <= cnt_n;
      sram_dq_oe <= is_write(state_n);
      sram_oe_n  <= !is_read(state_n);
      sram_we_n  <= is_write(state_n) ? we_n_n : 1'b1;
      if (is_access(state_n))
        sram_addr <= addr_n;
      if (is_write(state_n))
        sram_dq_out <= wdat_n;
    end
  end

endmodule

// File: rtl/mem_stage_sram.sv
// MEM stage: 32-bit load/store as two 16-bit async SRAM accesses; freeze holds the pipeline for 2*WAIT_CYCLES+1 cycles.
// Optional one-entry read cache (MEM_STAGE_READ_CACHE_EN) lets a repeated load complete in IDLE without freezing.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter logic [WORD_LEN-1:0] BASE_ADDR     = 32'd1024,
  parameter int                  WAIT_CYCLES   = 2,
  parameter int                  SRAM_ADDR_LEN = SRAM_ADDR_LEN_DEF
) (
  input logic             clk,
  input logic             rst,
  mem_stage_sram_if.slave ms
);

  localparam int WW = SRAM_ADDR_LEN - 1;

  ms_state_t                state;
  ms_state_t                state_n;
  logic [WORD_LEN-1:0]      off;
  logic [WW-1:0]            word_in;
  logic [WW-1:0]            word_q;
  logic [WW-1:0]            word_n;
  logic [WORD_LEN-1:0]      data_q;
  logic [WORD_LEN-1:0]      data_n;
  logic [SRAM_ADDR_LEN-1:0] addr_n;
  logic [SRAM_DQ_LEN-1:0]   wdat_n;
  logic [SRAM_DQ_LEN-1:0]   rd_lo_q;
  logic [WORD_LEN-1:0]      rd_val_q;
  logic                     last;
  logic                     hit;
  logic [WORD_LEN-1:0]      hit_dat;
  logic                     addr_unused;

  // Offsets beyond the SRAM are folded silently; the discarded bits go nowhere.
  assign off         = ms.ALUResIn - BASE_ADDR;
  assign word_in     = off[SRAM_ADDR_LEN:2];
  assign addr_unused = ^{off[WORD_LEN-1:SRAM_ADDR_LEN+1], off[1:0]};

`ifdef MEM_STAGE_READ_CACHE_EN
  logic                cache_vld;
  logic [WW-1:0]       cache_word;
  logic [WORD_LEN-1:0] cache_dat;

  assign hit     = (state == MS_IDLE) && ms.MEM_R_EN_IN && !ms.MEM_W_EN_IN &&
                   cache_vld && (cache_word == word_in);
  assign hit_dat = cache_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld <= 1'b0;
    end else if (state == MS_RD_HI && last) begin
      cache_vld  <= 1'b1;
      cache_word <= word_q;
      cache_dat  <= {ms.SRAM_DQ_IN, rd_lo_q};
    end else if (state == MS_WR_HI && last && cache_vld && cache_word == word_q) begin
      cache_dat <= data_q;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_dat = '0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      MS_IDLE: begin
        if (ms.MEM_W_EN_IN)
          state_n = MS_WR_LO;
        else if (ms.MEM_R_EN_IN && !hit)
          state_n = MS_RD_LO;
      end
      MS_RD_LO: if (last) state_n = MS_RD_HI;
      MS_RD_HI: if (last) state_n = MS_DONE;
      MS_WR_LO: if (last) state_n = MS_WR_HI;
      MS_WR_HI: if (last) state_n = MS_DONE;
      MS_DONE:  state_n = MS_IDLE;
      default:  state_n = MS_IDLE;
    endcase
  end

  // The first strobe edge must see the live request, not the not-yet-latched copy.
  always_comb begin
    word_n = (state == MS_IDLE) ? word_in : word_q;
    data_n = (state == MS_IDLE) ? ms.stValIn : data_q;
    addr_n = {word_n, is_hi(state_n)};
    wdat_n = is_hi(state_n) ? data_n[31:16] : data_n[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MS_IDLE;
      word_q   <= '0;
      data_q   <= '0;
      rd_lo_q  <= '0;
      rd_val_q <= '0;
    end else begin
      state <= state_n;
      if (state == MS_IDLE && state_n != MS_IDLE) begin
        word_q <= word_in;
        data_q <= ms.stValIn;
      end
      if (state == MS_RD_LO && last)
        rd_lo_q <= ms.SRAM_DQ_IN;
      if (state == MS_RD_HI && last)
        rd_val_q <= {ms.SRAM_DQ_IN, rd_lo_q};
      else if (hit)
        rd_val_q <= hit_dat;
    end
  end

  assign ms.freeze     = ((state == MS_IDLE) && (ms.MEM_R_EN_IN || ms.MEM_W_EN_IN) && !hit) ||
                         is_access(state);
  assign ms.memReadVal = hit ? hit_dat : rd_val_q;

  mem_stage_sram_half_access #(
    .WAIT_CYCLES   (WAIT_CYCLES),
    .SRAM_ADDR_LEN (SRAM_ADDR_LEN)
  ) u_half (
    .clk         (clk),
    .rst         (rst),
    .state       (state),
    .state_n     (state_n),
    .addr_n      (addr_n),
    .wdat_n      (wdat_n),
    .last        (last),
    .sram_addr   (ms.SRAM_ADDR),
    .sram_dq_out (ms.SRAM_DQ_OUT),
    .sram_dq_oe  (ms.SRAM_DQ_OE),
    .sram_we_n   (ms.SRAM_WE_N),
    .sram_oe_n   (ms.SRAM_OE_N)
  );

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: table of load/store vectors against a behavioural 16-bit SRAM,
// read results checked through a scoreboard queue, plus a reset-during-write sequence.
module tb_mem_stage_sram;
  import mem_stage_sram_pkg::*;

  localparam int W  = 2;
  localparam int AL = 18;
`ifdef MEM_STAGE_READ_CACHE_EN
  localparam int HIT_CYC = 0;
`else
  localparam int HIT_CYC = 2 * W + 1;
`endif

  typedef struct {
    logic          rd;
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   sdat;
    int            cyc;
    logic [31:0]   rdat;
    logic [AL-1:0] alo;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_sram_if #(.SRAM_ADDR_LEN(AL)) ifc ();

  mem_stage_sram #(
    .BASE_ADDR     (32'd1024),
    .WAIT_CYCLES   (W),
    .SRAM_ADDR_LEN (AL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ms  (ifc.slave)
  );

  // Behavioural async SRAM: write lands at the end of a WE_N-low cycle, read is combinational.
  logic [15:0] sram [0:1023];
  logic        sram_addr_unused;
  assign sram_addr_unused = ^ifc.SRAM_ADDR[AL-1:10];
  assign ifc.SRAM_DQ_IN   = !ifc.SRAM_OE_N ? sram[ifc.SRAM_ADDR[9:0]] : 16'h0000;

  always @(posedge clk) begin
    if (rst) begin
      sram[4] <= 16'h1111;
      sram[5] <= 16'hA5A5;
      sram[6] <= 16'h2222;
      sram[7] <= 16'h5A5A;
    end else if (!ifc.SRAM_WE_N) begin
      sram[ifc.SRAM_ADDR[9:0]] <= ifc.SRAM_DQ_OUT;
    end
  end

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_rd;
  vec_t        vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int            nfz, nwe, noe, nacc;
    logic [AL-1:0] a_first, a_last;
    logic [15:0]   d_first, d_last;
    logic [31:0]   exp_rd;
    logic          rd_only;
    nfz = 0; nwe = 0; noe = 0; nacc = 0;
    a_first = '0; a_last = '0; d_first = '0; d_last = '0;
    rd_only = v.rd && !v.wr;
    @(negedge clk);
    ifc.MEM_R_EN_IN = v.rd;
    ifc.MEM_W_EN_IN = v.wr;
    ifc.ALUResIn    = v.addr;
    ifc.stValIn     = v.sdat;
    if (rd_only) sb_q.push_back(v.rdat);
    #1;
    while (ifc.freeze && nfz < 50) begin
      nfz++;
      if (!ifc.SRAM_WE_N) begin
        nwe++;
        if (nwe == 1) d_first = ifc.SRAM_DQ_OUT;
        d_last = ifc.SRAM_DQ_OUT;
      end
      if (!ifc.SRAM_OE_N) noe++;
      if (!ifc.SRAM_OE_N || ifc.SRAM_DQ_OE) begin
        nacc++;
        if (nacc == 1) a_first = ifc.SRAM_ADDR;
        a_last = ifc.SRAM_ADDR;
      end
      @(negedge clk); #1;
    end
    chk("freeze_cycles", nfz, v.cyc);
    if (rd_only) begin
      exp_rd = sb_q.pop_front();
      chk("read_val", ifc.memReadVal, exp_rd);
      last_rd = exp_rd;
    end else begin
      chk("read_hold", ifc.memReadVal, last_rd);
    end
    chk("we_low_cycles", nwe, v.wr ? 2 * (W - 1) : 0);
    chk("oe_low_cycles", noe, (rd_only && v.cyc != 0) ? 2 * W : 0);
    if (v.cyc != 0) begin
      chk("sram_addr_lo", a_first, v.alo);
      chk("sram_addr_hi", a_last, v.alo + 1);
    end
    if (v.wr) begin
      chk("dq_out_lo", d_first, v.sdat[15:0]);
      chk("dq_out_hi", d_last, v.sdat[31:16]);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 5,       32'h0,        18'd0};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        5,       32'hDEADBEEF, 18'd0};
    vecs[2] = '{1'b1, 1'b0, 32'd1024, 32'h0,        HIT_CYC, 32'hDEADBEEF, 18'd0};
    vecs[3] = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 5,       32'h0,        18'd0};
    vecs[4] = '{1'b1, 1'b0, 32'd1024, 32'h0,        HIT_CYC, 32'h12345678, 18'd0};
    vecs[5] = '{1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 5,       32'h0,        18'd2};
    vecs[6] = '{1'b1, 1'b0, 32'd1028, 32'h0,        5,       32'hCAFEF00D, 18'd2};
    vecs[7] = '{1'b1, 1'b0, 32'd1032, 32'h0,        5,       32'hA5A51111, 18'd4};
    vecs[8] = '{1'b1, 1'b0, 32'd1036, 32'h0,        5,       32'h5A5A2222, 18'd6};
    vecs[9] = '{1'b1, 1'b0, 32'd1036, 32'h0,        5,       32'h5A5A2222, 18'd6};

    rst = 1'b1;
    ifc.MEM_R_EN_IN = 1'b0;
    ifc.MEM_W_EN_IN = 1'b0;
    ifc.ALUResIn    = '0;
    ifc.stValIn     = '0;
    last_rd         = '0;
    repeat (3) @(negedge clk);
    chk("rst_freeze",     ifc.freeze,      0);
    chk("rst_we_n",       ifc.SRAM_WE_N,   1);
    chk("rst_oe_n",       ifc.SRAM_OE_N,   1);
    chk("rst_dq_oe",      ifc.SRAM_DQ_OE,  0);
    chk("rst_sram_addr",  ifc.SRAM_ADDR,   0);
    chk("rst_dq_out",     ifc.SRAM_DQ_OUT, 0);
    chk("rst_read_val",   ifc.memReadVal,  0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset in the second cycle of WR_LO aborts the store and clears the result.
    @(negedge clk);
    ifc.MEM_R_EN_IN = 1'b0;
    ifc.MEM_W_EN_IN = 1'b1;
    ifc.ALUResIn    = 32'd1040;
    ifc.stValIn     = 32'h0BADF00D;
    @(negedge clk);
    chk("wr_lo_we_n_c1", ifc.SRAM_WE_N, 0);
    @(negedge clk);
    chk("wr_lo_we_n_c2", ifc.SRAM_WE_N, 1);
    chk("wr_lo_dq_oe_c2", ifc.SRAM_DQ_OE, 1);
    rst = 1'b1;
    ifc.MEM_W_EN_IN = 1'b0;
    @(negedge clk);
    chk("abort_freeze",   ifc.freeze,     0);
    chk("abort_we_n",     ifc.SRAM_WE_N,  1);
    chk("abort_oe_n",     ifc.SRAM_OE_N,  1);
    chk("abort_dq_oe",    ifc.SRAM_DQ_OE, 0);
    chk("abort_read_val", ifc.memReadVal, 0);
    rst = 1'b0;
    last_rd = '0;

    run_vec(vecs[9]);

    @(negedge clk);
    ifc.MEM_R_EN_IN = 1'b0;
    ifc.MEM_W_EN_IN = 1'b0;
    #1;
    chk("idle_freeze", ifc.freeze, 0);
    @(negedge clk);
    chk("idle_read_hold", ifc.memReadVal, last_rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
